// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types, opcode constants and the round-robin
// search helper for the I2C command arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int DEF_TIMEOUT_CYC = 400000;

    // Index of the first set bit of req[n-1:0], searching upward from
    // last+1 and wrapping.  Returns last when req is empty.
    // The loop is fixed at 8 so it unrolls to a static mux tree.
    function automatic int rr_pick(
        input logic [7:0] req,
        input int         last,
        input int         n
    );
        int r;
        int idx;
        r = last;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = last + k;
                if (idx >= n) idx = idx - n;
                if (req[3'(idx)]) r = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if: command/status port of the shared I2C master.
// master: arbiter side (drives command), slave: engine side.
interface i2c_cmd_arbiter_if;

    logic       m_newd;
    logic       m_op;
    logic [6:0] m_addr;
    logic [7:0] m_din;
    logic       m_abort;
    logic       m_busy;
    logic       m_done;
    logic [7:0] m_dout;
    logic       m_ack_err;

    modport master (
        output m_newd, m_op, m_addr, m_din, m_abort,
        input  m_busy, m_done, m_dout, m_ack_err
    );

    modport slave (
        input  m_newd, m_op, m_addr, m_din, m_abort,
        output m_busy, m_done, m_dout, m_ack_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick with a registered
// last-grant pointer.  Ports: req_i, advance_i (commit pick), pick_o.
module rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [$clog2(N)-1:0] pick_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q;
    logic [7:0]    req8;

    always_comb begin
        req8        = '0;
        req8[N-1:0] = req_i;
    end

    assign pick_o = IW'(rr_pick(req8, int'(last_q), N));

    // Starts at N-1 so requester 0 wins the first search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else if (advance_i) begin
            last_q <= pick_o;
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C master among NREQ
// clients; latches the command, supervises with a timeout, returns result.
// Ports: req/req_rw/req_addr/req_wdata in, gnt/rsp_* out, m_if to engine.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    i2c_cmd_arbiter_if.master    m_if
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = $clog2(NREQ);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [7:0]      rsp_rdata_q;
    logic            rsp_err_q;
    logic            rsp_timeout_q;
    logic            newd_q;
    logic            abort_q;
    logic            op_q;
    logic [6:0]      addr_q;
    logic [7:0]      din_q;
    logic [CW-1:0]   cnt_q;

    logic [IW-1:0]   pick;
    logic            advance;
    logic [NREQ-1:0] sel_oh;
    logic            sel_rw;
    logic [6:0]      sel_addr;
    logic [7:0]      sel_din;

    assign advance = (state_q == ST_IDLE) && (|req);

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .advance_i (advance),
        .pick_o    (pick)
    );

    always_comb begin
        sel_oh   = '0;
        sel_rw   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[7*i +: 7];
                sel_din   = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            newd_q        <= 1'b0;
            abort_q       <= 1'b0;
            op_q          <= OP_WRITE;
            addr_q        <= '0;
            din_q         <= '0;
            cnt_q         <= '0;
        end else begin
            newd_q      <= 1'b0;
            abort_q     <= 1'b0;
            rsp_valid_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q   <= sel_oh;
                        op_q    <= sel_rw;
                        addr_q  <= sel_addr;
                        din_q   <= sel_din;
                        newd_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    cnt_q <= cnt_q + CW'(1);
                    // done beats a same-cycle timeout
                    if (m_if.m_done) begin
                        rsp_valid_q   <= gnt_q;
                        rsp_rdata_q   <= (op_q == OP_READ) ?
                                         m_if.m_dout : 8'h00;
                        rsp_err_q     <= m_if.m_ack_err;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        abort_q       <= 1'b1;
                        rsp_valid_q   <= gnt_q;
                        rsp_rdata_q   <= 8'h00;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (state_q == ST_WAIT_BUSY &&
                                 m_if.m_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_RESP: begin
                    gnt_q         <= '0;
                    rsp_rdata_q   <= '0;
                    rsp_err_q     <= 1'b0;
                    rsp_timeout_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    assign m_if.m_newd  = newd_q;
    assign m_if.m_abort = abort_q;
    assign m_if.m_op    = op_q;
    assign m_if.m_addr  = addr_q;
    assign m_if.m_din   = din_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed bench; the bench plays the I2C
// master engine and the requesters around i2c_cmd_arbiter.
module tb_i2c_cmd_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 50;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0]      req_rw;
    logic [27:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [3:0]      gnt;
    logic [3:0]      rsp_valid;
    logic [7:0]      rsp_rdata;
    logic            rsp_err;
    logic            rsp_timeout;

    int n_chk;
    int n_fail;

    i2c_cmd_arbiter_if mif ();

    i2c_cmd_arbiter #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .m_if        (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1);
    end

    typedef struct {
        bit         seen;
        int         lat;
        logic [3:0] gnt;
        logic       op;
        logic [6:0] addr;
        logic [7:0] din;
        logic       newd2;
        logic [3:0] valid;
        logic [7:0] rdata;
        logic       err;
        logic       tmo;
        logic       abort;
        logic [3:0] valid2;
        logic [3:0] gnt2;
    } obs_t;

    // Engine model: waits for the command strobe, stays busy for
    // busy_cyc cycles, then returns done.  Records what it sees.
    // mode 1: requesters release at response; mode 2: drop at grant.
    task automatic do_txn(
        input  logic [7:0] dout,
        input  logic       ack,
        input  int         busy_cyc,
        input  int         mode,
        output obs_t       o
    );
        o = '{default: 0};
        o.lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.m_newd === 1'b1) begin
                o.seen = 1'b1;
                o.lat  = i;
                break;
            end
        end
        if (!o.seen) return;
        o.gnt  = gnt;
        o.op   = mif.m_op;
        o.addr = mif.m_addr;
        o.din  = mif.m_din;
        if (mode == 2) req = '0;
        @(negedge clk);
        o.newd2 = mif.m_newd;
        mif.m_busy = (busy_cyc > 0);
        repeat (busy_cyc) @(negedge clk);
        mif.m_busy    = 1'b0;
        mif.m_done    = 1'b1;
        mif.m_dout    = dout;
        mif.m_ack_err = ack;
        @(negedge clk);
        mif.m_done    = 1'b0;
        mif.m_dout    = 8'h00;
        mif.m_ack_err = 1'b0;
        o.valid = rsp_valid;
        o.rdata = rsp_rdata;
        o.err   = rsp_err;
        o.tmo   = rsp_timeout;
        o.abort = mif.m_abort;
        if (mode == 1) req = '0;
        @(negedge clk);
        o.valid2 = rsp_valid;
        o.gnt2   = gnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0 || rsp_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_gnt_valid: got %b/%b want 0000/0000",
                     gnt, rsp_valid);
        end
        n_chk++;
        if ({mif.m_newd, mif.m_abort, mif.m_op,
             mif.m_addr, mif.m_din} !== 18'h0) begin
            n_fail++;
            $display("FAIL rst_mcmd: got %b%b%b %h %h want all zero",
                     mif.m_newd, mif.m_abort, mif.m_op,
                     mif.m_addr, mif.m_din);
        end
        n_chk++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== 10'h0) begin
            n_fail++;
            $display("FAIL rst_rsp: got %h %b %b want 00 0 0",
                     rsp_rdata, rsp_err, rsp_timeout);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (gnt !== 4'b0 || mif.m_newd !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_noreq: gnt %b newd %b want 0000 0",
                     gnt, mif.m_newd);
        end
    endtask

    task automatic test_single_write();
        obs_t o;
        req_rw         = 4'b0000;
        req_addr[0+:7] = 7'h50;
        req_wdata[0+:8] = 8'hA5;
        req            = 4'b0001;
        do_txn(8'hFF, 1'b0, 3, 1, o);
        n_chk++;
        if (o.lat !== 0) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d want 0", o.lat);
        end
        n_chk++;
        if (o.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wr_gnt: got %b want 0001", o.gnt);
        end
        n_chk++;
        if (o.addr !== 7'h50 || o.din !== 8'hA5 || o.op !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_cmd: got %h %h %b want 50 a5 0",
                     o.addr, o.din, o.op);
        end
        n_chk++;
        if (o.newd2 !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_newd_pulse: got %b want 0", o.newd2);
        end
        n_chk++;
        if (o.valid !== 4'b0001 || o.rdata !== 8'h00 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rsp: got %b %h %b want 0001 00 0",
                     o.valid, o.rdata, o.err);
        end
        n_chk++;
        if (o.valid2 !== 4'b0 || o.gnt2 !== 4'b0) begin
            n_fail++;
            $display("FAIL wr_after: valid %b gnt %b want 0000 0000",
                     o.valid2, o.gnt2);
        end
    endtask

    task automatic test_single_read();
        obs_t o;
        req_rw          = 4'b0100;
        req_addr[14+:7] = 7'h23;
        req_wdata[16+:8] = 8'h00;
        req             = 4'b0100;
        do_txn(8'h3C, 1'b0, 2, 1, o);
        n_chk++;
        if (o.gnt !== 4'b0100 || o.op !== 1'b1 || o.addr !== 7'h23) begin
            n_fail++;
            $display("FAIL rd_cmd: got %b %b %h want 0100 1 23",
                     o.gnt, o.op, o.addr);
        end
        n_chk++;
        if (o.valid !== 4'b0100 || o.rdata !== 8'h3C ||
            o.err !== 1'b0 || o.tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_rsp: got %b %h %b %b want 0100 3c 0 0",
                     o.valid, o.rdata, o.err, o.tmo);
        end
    endtask

    task automatic test_fairness();
        obs_t o;
        int   exp_idx[8];
        exp_idx = '{3, 0, 1, 2, 3, 0, 1, 2};
        req_rw = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_addr[7*i +: 7]  = 7'(7'h10 + i);
            req_wdata[8*i +: 8] = 8'(8'h80 + i);
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            do_txn(8'h00, 1'b0, k % 3, (k == 7) ? 1 : 0, o);
            n_chk++;
            if (o.gnt !== (4'b0001 << exp_idx[k]) || o.lat !== 0) begin
                n_fail++;
                $display("FAIL rr_gnt%0d: got %b lat %0d want idx %0d lat 0",
                         k, o.gnt, o.lat, exp_idx[k]);
            end
            n_chk++;
            if (o.addr !== 7'(7'h10 + exp_idx[k]) ||
                o.valid !== (4'b0001 << exp_idx[k])) begin
                n_fail++;
                $display("FAIL rr_cmd%0d: addr %h valid %b want idx %0d",
                         k, o.addr, o.valid, exp_idx[k]);
            end
        end
    endtask

    task automatic test_nack();
        obs_t o;
        req_rw          = 4'b0000;
        req_addr[7+:7]  = 7'h3A;
        req_wdata[8+:8] = 8'h5E;
        req             = 4'b0010;
        do_txn(8'h00, 1'b1, 1, 1, o);
        n_chk++;
        if (o.valid !== 4'b0010 || o.err !== 1'b1 ||
            o.tmo !== 1'b0 || o.abort !== 1'b0) begin
            n_fail++;
            $display("FAIL nack_rsp: got %b err %b tmo %b ab %b want 0010 1 0 0",
                     o.valid, o.err, o.tmo, o.abort);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        bit   hit;
        int   k;
        req_rw          = 4'b1000;
        req_addr[21+:7] = 7'h61;
        req             = 4'b1000;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.m_newd === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!hit || gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL to_issue: seen %b gnt %b want 1 1000", hit, gnt);
        end
        mif.m_busy = 1'b1;
        mif.m_dout = 8'h77;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (mif.m_abort === 1'b1) break;
        end
        n_chk++;
        if (k !== TMO + 1) begin
            n_fail++;
            $display("FAIL to_abort_cycle: got %0d want %0d", k, TMO + 1);
        end
        n_chk++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 ||
            rsp_timeout !== 1'b1 || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL to_rsp: got %b %b %b %h want 1000 1 1 00",
                     rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
        req        = '0;
        mif.m_busy = 1'b0;
        mif.m_dout = 8'h00;
        @(negedge clk);
        n_chk++;
        if (mif.m_abort !== 1'b0 || rsp_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL to_pulse: abort %b valid %b want 0 0000",
                     mif.m_abort, rsp_valid);
        end
        req_rw         = 4'b0001;
        req_addr[0+:7] = 7'h11;
        req            = 4'b0001;
        do_txn(8'h5A, 1'b0, 2, 1, o);
        n_chk++;
        if (o.valid !== 4'b0001 || o.rdata !== 8'h5A ||
            o.err !== 1'b0 || o.tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL to_recover: got %b %h %b %b want 0001 5a 0 0",
                     o.valid, o.rdata, o.err, o.tmo);
        end
    endtask

    task automatic test_collision();
        bit hit;
        req_rw         = 4'b0000;
        req_addr[0+:7] = 7'h2C;
        req            = 4'b0001;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.m_newd === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL col_issue: newd seen %b want 1", hit);
        end
        mif.m_busy = 1'b1;
        repeat (TMO) @(negedge clk);
        mif.m_busy    = 1'b0;
        mif.m_done    = 1'b1;
        mif.m_ack_err = 1'b0;
        @(negedge clk);
        mif.m_done = 1'b0;
        n_chk++;
        if (rsp_valid !== 4'b0001 || mif.m_abort !== 1'b0 ||
            rsp_timeout !== 1'b0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL col_rsp: got %b ab %b tmo %b err %b want 0001 0 0 0",
                     rsp_valid, mif.m_abort, rsp_timeout, rsp_err);
        end
        req = '0;
        @(negedge clk);
        n_chk++;
        if (mif.m_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL col_late_abort: got %b want 0", mif.m_abort);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   hit;
        bit   stray;
        req_rw          = 4'b0100;
        req_addr[14+:7] = 7'h42;
        req             = 4'b0100;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.m_newd === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        mif.m_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (!hit || gnt !== 4'b0 || rsp_valid !== 4'b0 ||
            {mif.m_newd, mif.m_abort, mif.m_op,
             mif.m_addr, mif.m_din} !== 18'h0) begin
            n_fail++;
            $display("FAIL rstmid_out: seen %b gnt %b op %b addr %h want 1 0000 0 00",
                     hit, gnt, mif.m_op, mif.m_addr);
        end
        req        = '0;
        mif.m_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0 || mif.m_abort !== 1'b0) stray = 1'b1;
        end
        n_chk++;
        if (stray) begin
            n_fail++;
            $display("FAIL rstmid_stray: got response/abort want none");
        end
        req_rw = 4'b0000;
        req    = 4'b1111;
        do_txn(8'h00, 1'b0, 1, 1, o);
        n_chk++;
        if (o.gnt !== 4'b0001 || o.valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_ptr: gnt %b valid %b want 0001 0001",
                     o.gnt, o.valid);
        end
    endtask

    task automatic test_req_drop();
        obs_t o;
        req_rw          = 4'b0000;
        req_addr[7+:7]  = 7'h19;
        req_wdata[8+:8] = 8'hC3;
        req             = 4'b0010;
        do_txn(8'h00, 1'b0, 2, 2, o);
        n_chk++;
        if (o.gnt !== 4'b0010 || o.addr !== 7'h19 || o.din !== 8'hC3) begin
            n_fail++;
            $display("FAIL drop_cmd: got %b %h %h want 0010 19 c3",
                     o.gnt, o.addr, o.din);
        end
        n_chk++;
        if (o.valid !== 4'b0010 || o.gnt2 !== 4'b0) begin
            n_fail++;
            $display("FAIL drop_rsp: valid %b gnt_after %b want 0010 0000",
                     o.valid, o.gnt2);
        end
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        req           = '0;
        req_rw        = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mif.m_busy    = 1'b0;
        mif.m_done    = 1'b0;
        mif.m_dout    = 8'h00;
        mif.m_ack_err = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_fairness();
        test_nack();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_req_drop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
